// File: rtl/dma_fifo_ctrl.sv
// FIFO controller sequencing a dual-port sram with registered read data; macro DMA_FIFO_STATS_EN adds a watermark.
// Latency: a word pushed at edge E is read at edge E+1 and pop_valid rises after E+1 (2 cycles from empty).
// Backpressure: push_ready = !full (no same-cycle bypass); pop_data holds while pop_valid & !pop_ready.
module dma_fifo_ctrl #(
   parameter int FIFO_PTR   = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int A_MAX      = 2**FIFO_PTR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [FIFO_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [FIFO_WIDTH-1:0] pop_data,
   output logic                  sram_wren,
   output logic [FIFO_PTR-1:0]   sram_wrptr,
   output logic [FIFO_WIDTH-1:0] sram_wrdata,
   output logic                  sram_rden,
   output logic [FIFO_PTR-1:0]   sram_rdptr,
   input  logic [FIFO_WIDTH-1:0] sram_rddata,
   output logic                  full,
   output logic                  empty,
   output logic [FIFO_PTR:0]     count,
   output logic [FIFO_PTR:0]     max_count
);

   localparam logic [FIFO_PTR:0] DEPTH = (FIFO_PTR+1)'(A_MAX);
   localparam logic [FIFO_PTR:0] ONE   = (FIFO_PTR+1)'(1);

   // Pointers carry an extra wrap bit so a full sram is distinguishable from empty.
   logic [FIFO_PTR:0] wp;
   logic [FIFO_PTR:0] rp;
   logic [FIFO_PTR:0] sram_cnt;
   logic              out_v;
   logic              clr;

   assign clr      = rst | flush;
   assign sram_cnt = wp - rp;

   // Status and sram port decode; a clearing cycle suppresses both sram ports.
   always_comb begin
      full        = (sram_cnt == DEPTH);
      push_ready  = !full;
      sram_wren   = push_valid & push_ready & !clr;
      sram_wrptr  = wp[FIFO_PTR-1:0];
      sram_wrdata = push_data;
      // A read only issues when the output register is free or being emptied this cycle,
      // which keeps pop_data stable during a stall.
      sram_rden   = (sram_cnt != '0) & (!out_v | pop_ready) & !clr;
      sram_rdptr  = rp[FIFO_PTR-1:0];
      pop_valid   = out_v;
      pop_data    = sram_rddata;
      count       = sram_cnt + {{FIFO_PTR{1'b0}}, out_v};
      empty       = (count == '0);
   end

   // Pointer and output-stage state; clear wins over any push or pop.
   always_ff @(posedge clk) begin
      if (clr) begin
         wp    <= '0;
         rp    <= '0;
         out_v <= 1'b0;
      end else begin
         if (sram_wren) begin
            wp <= wp + ONE;
         end
         if (sram_rden) begin
            rp    <= rp + ONE;
            out_v <= 1'b1;
         end else if (out_v & pop_ready) begin
            out_v <= 1'b0;
         end
      end
   end

`ifdef DMA_FIFO_STATS_EN
   logic [FIFO_PTR:0] max_q;

   // High watermark of count; survives flush so it reflects the whole run since reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q <= '0;
      end else if (count > max_q) begin
         max_q <= count;
      end
   end

   assign max_count = max_q;
`else
   assign max_count = '0;
`endif

endmodule

// File: tb/tb_dma_fifo_ctrl.sv
module tb_dma_fifo_ctrl;

   localparam int P = 4;
   localparam int W = 16;
   localparam int D = 2**P;

   logic         clk = 1'b0;
   logic         rst, flush, push_valid, pop_ready;
   logic [W-1:0] push_data;
   logic         push_ready, pop_valid, sram_wren, sram_rden, full, empty;
   logic [W-1:0] pop_data, sram_wrdata, sram_rddata;
   logic [P-1:0] sram_wrptr, sram_rdptr;
   logic [P:0]   count, max_count;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   dma_fifo_ctrl #(.FIFO_PTR(P), .FIFO_WIDTH(W), .A_MAX(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
      .sram_wren(sram_wren), .sram_wrptr(sram_wrptr), .sram_wrdata(sram_wrdata),
      .sram_rden(sram_rden), .sram_rdptr(sram_rdptr), .sram_rddata(sram_rddata),
      .full(full), .empty(empty), .count(count), .max_count(max_count)
   );

   // Behavioural dual-port sram with registered read output.
   logic [W-1:0] mem [D];
   always @(posedge clk) begin
      if (sram_wren) mem[sram_wrptr] <= sram_wrdata;
      if (sram_rden) sram_rddata <= mem[sram_rdptr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every accepted pop must match the oldest expected word.
   always @(negedge clk) begin
      if (!rst && pop_valid && pop_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_unexpected: got %0h expected no word", pop_data);
         end else begin
            chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_wait(input string name);
      pop_ready  = 1'b1;
      push_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (empty) break;
         step();
      end
      chk({name, "_empty"}, 32'(empty), 32'd1);
      chk({name, "_q_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; push_valid = 1'b1; push_data = 16'hdead; pop_ready = 1'b0;

      // Reset held two cycles with push_valid asserted.
      @(negedge clk);
      chk("rst_wren0", 32'(sram_wren), 32'd0);
      step();
      @(negedge clk);
      chk("rst_wren1", 32'(sram_wren), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_pop_valid", 32'(pop_valid), 32'd0);
      step();
      rst = 1'b0; push_valid = 1'b0;
      @(negedge clk);
      chk("rst_push_ready", 32'(push_ready), 32'd1);
      chk("rst_max_count", 32'(max_count), 32'd0);
      step();

      // Single word: write cycle 0, read cycle 1, pop_valid cycle 2, empty cycle 3.
      pop_ready = 1'b1; push_valid = 1'b1; push_data = 16'h1234;
      exp_q.push_back(16'h1234);
      @(negedge clk);
      chk("single_wren", 32'(sram_wren), 32'd1);
      step();
      push_valid = 1'b0;
      @(negedge clk);
      chk("single_rden_c1", 32'(sram_rden), 32'd1);
      chk("single_pv_c1", 32'(pop_valid), 32'd0);
      step();
      @(negedge clk);
      chk("single_pv_c2", 32'(pop_valid), 32'd1);
      step();
      @(negedge clk);
      chk("single_empty_c3", 32'(empty), 32'd1);
      chk("single_pv_c3", 32'(pop_valid), 32'd0);
      step();

      // Fill to A_MAX+1 with the consumer stalled.
      pop_ready = 1'b0;
      for (int i = 0; i < D + 1; i++) begin
         push_valid = 1'b1; push_data = 16'(i);
         exp_q.push_back(16'(i));
         @(negedge clk);
         chk($sformatf("fill_wren_%0d", i), 32'(sram_wren), 32'd1);
         step();
      end
      push_data = 16'h0011;
      @(negedge clk);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_push_ready", 32'(push_ready), 32'd0);
      chk("fill_count", 32'(count), 32'd17);
      chk("fill_18th_wren", 32'(sram_wren), 32'd0);
      step();
      @(negedge clk);
      chk("fill_count_held", 32'(count), 32'd17);
`ifdef DMA_FIFO_STATS_EN
      chk("fill_max_count", 32'(max_count), 32'd17);
`else
      chk("fill_max_count", 32'(max_count), 32'd0);
`endif
      push_valid = 1'b0;
      step();
      pop_ready = 1'b1;
      for (int i = 0; i < D + 1; i++) begin
         @(negedge clk);
         chk($sformatf("drain_pv_%0d", i), 32'(pop_valid), 32'd1);
         step();
      end
      @(negedge clk);
      chk("drain_empty", 32'(empty), 32'd1);
      step();

      // Continuous push+pop across two pointer wraps.
      for (int i = 0; i < 40; i++) begin
         push_valid = 1'b1; push_data = 16'(16'h0100 + i);
         exp_q.push_back(16'(16'h0100 + i));
         @(negedge clk);
         if (!sram_wren || count > 3) begin
            chk($sformatf("wrap_cycle_%0d_wren", i), 32'(sram_wren), 32'd1);
            chk($sformatf("wrap_cycle_%0d_count_le3", i), 32'(count <= 3), 32'd1);
         end
         step();
      end
      chk("wrap_count_after", 32'(count), 32'd2);
      drain_wait("wrap");
      step();

      // Stall with 4 words buffered.
      pop_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_valid = 1'b1; push_data = 16'(16'h0200 + i);
         exp_q.push_back(16'(16'h0200 + i));
         step();
      end
      push_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("stall_pv_%0d", c), 32'(pop_valid), 32'd1);
         chk($sformatf("stall_data_%0d", c), 32'(pop_data), 32'h0200);
         chk($sformatf("stall_rden_%0d", c), 32'(sram_rden), 32'd0);
         chk($sformatf("stall_count_%0d", c), 32'(count), 32'd4);
         step();
      end
      drain_wait("stall");
      step();

      // Reset so the watermark starts fresh, then buffer 10 words and flush.
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      pop_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push_valid = 1'b1; push_data = 16'(16'h0300 + i);
         exp_q.push_back(16'(16'h0300 + i));
         step();
      end
      push_valid = 1'b0;
      @(negedge clk);
      chk("flush_pre_count", 32'(count), 32'd10);
      step();
      flush = 1'b1; push_valid = 1'b1; push_data = 16'hbeef; pop_ready = 1'b1;
      @(negedge clk);
      chk("flush_wren", 32'(sram_wren), 32'd0);
      chk("flush_rden", 32'(sram_rden), 32'd0);
      step();
      exp_q.delete();
      flush = 1'b0; push_valid = 1'b0;
      @(negedge clk);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_pop_valid", 32'(pop_valid), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
`ifdef DMA_FIFO_STATS_EN
      chk("flush_max_count", 32'(max_count), 32'd10);
`else
      chk("flush_max_count", 32'(max_count), 32'd0);
`endif
      step();
      step();
      @(negedge clk);
      chk("flush_no_write", 32'(count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
